// File: rtl/protected_mem_requester_if.sv
// Command, response and RAM-port signals of the protected key-store requester.
// The master modport is the requester's view; slave is the bus/RAM side.
interface protected_mem_requester_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_addr;
   logic        mem_write;
   logic [31:0] mem_write_data;
   logic [31:0] mem_data;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, mem_data,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_write, mem_write_data
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, mem_data,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_write, mem_write_data
   );
endinterface

// File: rtl/protected_mem_requester.sv
// Bus-side initiator for the word-addressed key-store RAM. Sequences one read or write at a
// time onto a registered-read RAM port, returns one response per command, and refuses any
// write aimed at the immutable hash-key word before it can reach the RAM.
// Optional feature macro: PMR_WRITE_VERIFY_EN -- read back each write and flag a mismatch.
module protected_mem_requester #(
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned PROT_IDX = 0,
   parameter int unsigned CNT_W    = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   protected_mem_requester_if.master bus,
   output logic [CNT_W-1:0]         viol_cnt
);

`ifdef PMR_WRITE_VERIFY_EN
   typedef enum logic [2:0] {StIdle, StIssue, StWait, StVerify, StResp} state_e;
`else
   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;
`endif

   state_e            state_q;
   logic              wr_q;
   logic [ADDR_W-1:0] idx;
   logic              misaligned;
   logic              out_of_range;
   logic              prot_hit;

   // Decode the incoming command; only meaningful while idle.
   always_comb begin
      idx          = bus.cmd_addr[ADDR_W+1:2];
      misaligned   = (bus.cmd_addr[1:0] != 2'b00);
      out_of_range = ((bus.cmd_addr >> (ADDR_W + 2)) != 32'd0);
      prot_hit     = bus.cmd_write && (idx == ADDR_W'(PROT_IDX));
   end

   // Command sequencer; every output is registered here.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q            <= StIdle;
         wr_q               <= 1'b0;
         bus.cmd_ready      <= 1'b1;
         bus.rsp_valid      <= 1'b0;
         bus.rsp_rdata      <= 32'd0;
         bus.rsp_err        <= 1'b0;
         bus.mem_addr       <= 32'd0;
         bus.mem_write      <= 1'b0;
         bus.mem_write_data <= 32'd0;
         viol_cnt           <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.cmd_valid) begin
                  bus.cmd_ready <= 1'b0;
                  wr_q          <= bus.cmd_write;
                  if (misaligned || out_of_range || prot_hit) begin
                     // Rejected commands never touch the RAM port.
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_err   <= 1'b1;
                     bus.rsp_rdata <= 32'd0;
                     state_q       <= StResp;
                     if (!misaligned && !out_of_range && viol_cnt != {CNT_W{1'b1}}) begin
                        viol_cnt <= viol_cnt + 1'b1;
                     end
                  end else begin
                     bus.mem_addr       <= bus.cmd_addr;
                     bus.mem_write      <= bus.cmd_write;
                     bus.mem_write_data <= bus.cmd_wdata;
                     state_q            <= StIssue;
                  end
               end
            end
            StIssue: begin
               bus.mem_write <= 1'b0;
               state_q       <= StWait;
            end
            StWait: begin
               if (!wr_q) begin
                  bus.rsp_rdata <= bus.mem_data;
                  bus.rsp_err   <= 1'b0;
                  bus.rsp_valid <= 1'b1;
                  state_q       <= StResp;
               end else begin
`ifdef PMR_WRITE_VERIFY_EN
                  // mem_addr is still held, so the RAM is reading the freshly written word.
                  state_q <= StVerify;
`else
                  bus.rsp_rdata <= 32'd0;
                  bus.rsp_err   <= 1'b0;
                  bus.rsp_valid <= 1'b1;
                  state_q       <= StResp;
`endif
               end
            end
`ifdef PMR_WRITE_VERIFY_EN
            StVerify: begin
               if (bus.mem_data != bus.mem_write_data) begin
                  bus.rsp_err   <= 1'b1;
                  bus.rsp_rdata <= bus.mem_data;
               end else begin
                  bus.rsp_err   <= 1'b0;
                  bus.rsp_rdata <= 32'd0;
               end
               bus.rsp_valid <= 1'b1;
               state_q       <= StResp;
            end
`endif
            StResp: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  bus.cmd_ready <= 1'b1;
                  state_q       <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_protected_mem_requester.sv
// Randomised self-checking bench for protected_mem_requester against a word-array model.
module tb_protected_mem_requester;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned CNT_W  = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic [CNT_W-1:0] viol_cnt;
   logic             ram_load;
   logic [31:0]      ram [32];
   logic [31:0]      exp_ram [32];
   int               exp_viol;
   int               pulse_cnt = 0;
   int               prot_strobe = 0;
   int               n_checks = 0;
   int               n_errors = 0;

   protected_mem_requester_if bus ();

   protected_mem_requester #(
      .ADDR_W  (ADDR_W),
      .PROT_IDX(0),
      .CNT_W   (CNT_W)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .viol_cnt(viol_cnt)
   );

   always #5 clk = ~clk;

   // Registered-read RAM (read-before-write) plus strobe monitors.
   always @(posedge clk) begin
      if (ram_load) begin
         for (int i = 0; i < 32; i++) ram[i] <= exp_ram[i];
      end else if (bus.mem_write) begin
         ram[bus.mem_addr[6:2]] <= bus.mem_write_data;
      end
      bus.mem_data <= ram[bus.mem_addr[6:2]];
      if (bus.mem_write) begin
         pulse_cnt <= pulse_cnt + 1;
         if (bus.mem_addr[6:2] == 5'd0) prot_strobe <= prot_strobe + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one command, predict its outcome from the access rules, check the response.
   task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int hold);
      int          e_lat, e_pulses, lat, p0, widx;
      logic [31:0] e_rdata;
      logic        e_err;
      widx = int'(addr[6:2]);
      if (addr % 4 != 0 || addr >= 32'd128) begin
         e_lat = 1; e_err = 1'b1; e_rdata = 32'd0; e_pulses = 0;
      end else if (wr && widx == 0) begin
         e_lat = 1; e_err = 1'b1; e_rdata = 32'd0; e_pulses = 0;
         exp_viol++;
      end else if (wr) begin
`ifdef PMR_WRITE_VERIFY_EN
         e_lat = 4;
`else
         e_lat = 3;
`endif
         e_err = 1'b0; e_rdata = 32'd0; e_pulses = 1;
         exp_ram[widx] = wd;
      end else begin
         e_lat = 3; e_err = 1'b0; e_rdata = exp_ram[widx]; e_pulses = 0;
      end

      check_eq("cmd_ready_idle", bus.cmd_ready, 1'b1);
      p0 = pulse_cnt;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wd;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = $urandom_range(0, 1);
      bus.cmd_addr  = $urandom;
      bus.cmd_wdata = $urandom;
      lat = 1;
      while (!bus.rsp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check_eq("latency", lat, e_lat);
      check_eq("rsp_rdata", bus.rsp_rdata, e_rdata);
      check_eq("rsp_err", bus.rsp_err, e_err);
      // Busy commands offered while the response is held must be ignored.
      bus.cmd_valid = (hold > 0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check_eq("hold_valid", bus.rsp_valid, 1'b1);
         check_eq("hold_rdata", bus.rsp_rdata, e_rdata);
         check_eq("hold_err", bus.rsp_err, e_err);
         check_eq("hold_cmd_ready", bus.cmd_ready, 1'b0);
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      check_eq("rsp_done", bus.rsp_valid, 1'b0);
      check_eq("back_idle", bus.cmd_ready, 1'b1);
      check_eq("wr_pulses", pulse_cnt - p0, e_pulses);
      check_eq("viol_cnt", viol_cnt, (exp_viol > 255) ? 255 : exp_viol);
   endtask

   initial begin
      int          sel;
      logic [31:0] a;
      for (int i = 0; i < 32; i++) exp_ram[i] = $urandom;
      exp_ram[0]    = 32'h1035_9987;
      exp_ram[1]    = 32'hCAFE_0001;
      exp_viol      = 0;
      reset         = 1'b1;
      ram_load      = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 32'd0;
      bus.cmd_wdata = 32'd0;
      bus.rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset    = 1'b0;
      ram_load = 1'b0;

      check_eq("rst_cmd_ready", bus.cmd_ready, 1'b1);
      check_eq("rst_rsp_valid", bus.rsp_valid, 1'b0);
      check_eq("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      check_eq("rst_rsp_err", bus.rsp_err, 1'b0);
      check_eq("rst_mem_addr", bus.mem_addr, 32'd0);
      check_eq("rst_mem_write", bus.mem_write, 1'b0);
      check_eq("rst_mem_wdata", bus.mem_write_data, 32'd0);
      check_eq("rst_viol", viol_cnt, 0);

      run_cmd(1'b0, 32'h4, 32'd0, 0);
      run_cmd(1'b1, 32'h0, 32'hDEAD_BEEF, 0);
      run_cmd(1'b0, 32'h0, 32'd0, 0);
      run_cmd(1'b1, 32'h8, 32'h1234_5678, 0);
      run_cmd(1'b0, 32'h8, 32'd0, 0);
      run_cmd(1'b0, 32'h2, 32'd0, 0);
      run_cmd(1'b0, 32'h80, 32'd0, 0);
      run_cmd(1'b0, 32'h7C, 32'd0, 5);

      // Reset while a read sits in WAIT: aborted, no response.
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 32'h4;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset    = 1'b0;
      exp_viol = 0;
      check_eq("abort_cmd_ready", bus.cmd_ready, 1'b1);
      check_eq("abort_rsp_valid", bus.rsp_valid, 1'b0);
      check_eq("abort_rsp_rdata", bus.rsp_rdata, 32'd0);
      check_eq("abort_rsp_err", bus.rsp_err, 1'b0);
      check_eq("abort_mem_addr", bus.mem_addr, 32'd0);
      check_eq("abort_mem_write", bus.mem_write, 1'b0);
      check_eq("abort_mem_wdata", bus.mem_write_data, 32'd0);
      check_eq("abort_viol", viol_cnt, 0);
      repeat (3) begin
         @(posedge clk); #1;
         check_eq("abort_no_rsp", bus.rsp_valid, 1'b0);
      end

      for (int n = 0; n < 200; n++) begin
         sel = $urandom_range(0, 9);
         if (sel == 0) a = ($urandom & 32'h7C) | 32'($urandom_range(1, 3));
         else if (sel == 1) a = 32'($urandom_range(32, 1000)) << 2;
         else if (sel == 2) a = 32'h0;
         else a = 32'($urandom_range(0, 31)) << 2;
         run_cmd(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3));
      end

      for (int n = 0; n < 300; n++) run_cmd(1'b1, 32'h0, $urandom, 0);
      check_eq("viol_saturated", viol_cnt, 8'hFF);
      run_cmd(1'b0, 32'h0, 32'd0, 0);
      check_eq("prot_strobes", prot_strobe, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
